// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 UART receiver with a small receive FIFO and a
// Wishbone-style register interface.
//
// Ports:
//   wb_clk    in   sole clock, rising edge
//   wb_rst    in   asynchronous active-high reset
//   i_wb_adr  in   0 = DATA, 1 = STATUS
//   i_wb_dat  in   write data (STATUS bit2 clears OVR, bit3 clears FERR)
//   i_wb_we   in   write enable
//   i_wb_cyc  in   bus cycle request
//   o_wb_rdt  out  read data, updated on the acking edge
//   o_wb_ack  out  single-cycle acknowledge
//   i_rx      in   serial line, idle high, LSB first
//   o_irq     out  high while the FIFO holds data
//
// DATA read  : {23'b0, valid, byte}, pops the head when valid.
// STATUS read: {23'b0, count[4:0], ferr, ovr, full, nonempty}.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sampling 8 data bits at mid-bit
// STOP  | sampling the stop bit, push byte or flag framing error

module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  input  logic        i_rx,
  output logic        o_irq
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  DEPTH     = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q;
  logic        rx_meta_q, rxs_q, rxs_prev_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;

  logic        cnt_zero, push_req, ferr_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          ack_q, irq_q;
  logic [31:0]   rdt_q, rdt_d;

  logic nonempty, full, ack_edge, pop, push, ovr_set, status_wr;
  logic unused_dat;

  // Counters load N-1 and expire on the cycle they read zero, so a load
  // of N-1 spans N cycles.
  assign cnt_zero = (cnt_q == 16'd0);
  assign push_req = (state_q == STOP) && cnt_zero && rxs_q;
  assign ferr_set = (state_q == STOP) && cnt_zero && !rxs_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= 8'd0;
    end else begin
      rx_meta_q  <= i_rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      unique case (state_q)
        IDLE: begin
          // Edge, not level: a line left low (reset mid-frame, broken
          // stop bit) must not start a new frame.
          if (rxs_prev_q && !rxs_q) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt_zero) begin
            if (!rxs_q) begin
              state_q   <= DATA;
              cnt_q     <= FULL_LOAD;
              bit_idx_q <= 3'd0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (cnt_zero) begin
            shreg_q[bit_idx_q] <= rxs_q;
            cnt_q              <= FULL_LOAD;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (cnt_zero) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nonempty  = (count_q != 5'd0);
  assign full      = (count_q == DEPTH);
  assign ack_edge  = i_wb_cyc & ~ack_q;
  assign pop       = ack_edge & ~i_wb_we & ~i_wb_adr & nonempty;
  assign status_wr = ack_edge & i_wb_we & i_wb_adr;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push      = push_req & (~full | pop);
  assign ovr_set   = push_req & full & ~pop;

  assign unused_dat = ^{i_wb_dat[31:4], i_wb_dat[1:0]};

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // Set wins over a clear on the same edge.
    if (ovr_set)                         ovr_d = 1'b1;
    else if (status_wr && i_wb_dat[2])   ovr_d = 1'b0;
    else                                 ovr_d = ovr_q;

    if (ferr_set)                        ferr_d = 1'b1;
    else if (status_wr && i_wb_dat[3])   ferr_d = 1'b0;
    else                                 ferr_d = ferr_q;

    rdt_d = rdt_q;
    if (ack_edge) begin
      if (i_wb_we)       rdt_d = 32'd0;
      else if (i_wb_adr) rdt_d = {23'd0, count_q, ferr_q, ovr_q, full, nonempty};
      else               rdt_d = {23'd0, nonempty, nonempty ? mem_q[rd_ptr_q] : 8'h00};
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdt_q    <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      ack_q    <= ack_edge;
      rdt_q    <= rdt_d;
      irq_q    <= (count_d != 5'd0);
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge wb_clk) begin
    if (push) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = irq_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
module tb_servant_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        i_wb_adr = 1'b0;
  logic [31:0] i_wb_dat = 32'd0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        i_rx = 1'b1;
  logic        o_irq;

  servant_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .o_wb_rdt(o_wb_rdt),
    .o_wb_ack(o_wb_ack), .i_rx(i_rx), .o_irq(o_irq)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: bytes expected in the receive FIFO plus sticky flags.
  logic [7:0] sb_q[$];
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;

  typedef struct {
    logic [7:0]  data;
    logic        stop_bit;
    logic [31:0] exp_rdt;
    logic [31:0] exp_status;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Start bit is driven #1 after the task's first edge (edge 0); the stop
  // bit is sampled and the byte pushed on edge 155 for CPB=16.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    @(posedge wb_clk); #1 i_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge wb_clk);
      #1 i_rx = d[i];
    end
    repeat (CPB) @(posedge wb_clk);
    #1 i_rx = stop_bit;
    repeat (11) @(posedge wb_clk);
    #2;
    if (stop_bit) begin
      if (sb_q.size() < DEPTH) sb_q.push_back(d);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    repeat (5) @(posedge wb_clk);
    #1 i_rx = 1'b1;
    repeat (4) @(posedge wb_clk);
  endtask

  task automatic read_data(input string name, output logic [31:0] rdt);
    logic [31:0] exp;
    @(posedge wb_clk); #1;
    if (sb_q.size() > 0) exp = {23'd0, 1'b1, sb_q.pop_front()};
    else exp = 32'd0;
    i_wb_cyc = 1'b1; i_wb_adr = 1'b0; i_wb_we = 1'b0;
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b0;
    check({name, " ack"}, {31'd0, o_wb_ack}, 32'd1);
    rdt = o_wb_rdt;
    check(name, rdt, exp);
  endtask

  task automatic read_status(input string name, output logic [31:0] rdt);
    logic [31:0] exp;
    @(posedge wb_clk); #1;
    exp = {23'd0, 5'(sb_q.size()), m_ferr, m_ovr, sb_q.size() == DEPTH, sb_q.size() != 0};
    i_wb_cyc = 1'b1; i_wb_adr = 1'b1; i_wb_we = 1'b0;
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b0;
    rdt = o_wb_rdt;
    check(name, rdt, exp);
  endtask

  task automatic bus_write(input logic adr, input logic [31:0] val);
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b1; i_wb_adr = adr; i_wb_we = 1'b1; i_wb_dat = val;
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b0; i_wb_we = 1'b0; i_wb_dat = 32'd0;
    if (adr && val[2]) m_ovr = 1'b0;
    if (adr && val[3]) m_ferr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;

    vecs[0] = '{8'hA5, 1'b1, 32'h0000_01A5, 32'h0000_0011};
    vecs[1] = '{8'h00, 1'b1, 32'h0000_0100, 32'h0000_0011};
    vecs[2] = '{8'hFF, 1'b1, 32'h0000_01FF, 32'h0000_0011};
    vecs[3] = '{8'h3C, 1'b0, 32'h0000_0000, 32'h0000_0008};

    repeat (3) @(posedge wb_clk);
    #1;
    check("reset rdt", o_wb_rdt, 32'd0);
    check("reset ack", {31'd0, o_wb_ack}, 32'd0);
    check("reset irq", {31'd0, o_irq}, 32'd0);
    wb_rst = 1'b0;
    read_status("status after reset", r);

    // Single frames: good bytes and one with a broken stop bit.
    for (int v = 0; v < 4; v++) begin
      send_byte(vecs[v].data, vecs[v].stop_bit);
      check($sformatf("irq after frame %0d", v), {31'd0, o_irq}, {31'd0, vecs[v].stop_bit});
      read_status($sformatf("status frame %0d", v), r);
      check($sformatf("status const frame %0d", v), r, vecs[v].exp_status);
      read_data($sformatf("data frame %0d", v), r);
      check($sformatf("data const frame %0d", v), r, vecs[v].exp_rdt);
      @(posedge wb_clk); #1;
      check($sformatf("irq after read %0d", v), {31'd0, o_irq}, 32'd0);
      if (!vecs[v].stop_bit) begin
        bus_write(1'b1, 32'h8);
        read_status("ferr cleared", r);
        check("ferr cleared const", r, 32'd0);
      end
    end

    // Short low glitch must be rejected, then a real frame still decodes.
    @(posedge wb_clk); #1 i_rx = 1'b0;
    repeat (5) @(posedge wb_clk);
    #1 i_rx = 1'b1;
    repeat (40) @(posedge wb_clk);
    read_status("glitch status", r);
    check("glitch status const", r, 32'd0);
    send_byte(8'h5A, 1'b1);
    read_data("after glitch data", r);
    check("after glitch const", r, 32'h15A);

    // Overflow: five bytes into a four-deep FIFO.
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
    read_status("overflow status", r);
    check("overflow status const", r, 32'h47);
    for (int b = 1; b <= 5; b++) begin
      read_data($sformatf("overflow read %0d", b), r);
      check($sformatf("overflow read const %0d", b), r, (b <= 4) ? 32'h100 + 32'(b) : 32'd0);
    end
    bus_write(1'b1, 32'h4);
    read_status("ovr cleared", r);
    check("ovr cleared const", r, 32'd0);

    // Full FIFO: pop acked on the same edge as the stop-bit push.
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
    read_status("full status", r);
    check("full status const", r, 32'h43);
    fork
      send_byte(8'h05, 1'b1);
      begin
        logic [31:0] rr;
        @(posedge wb_clk);
        repeat (153) @(posedge wb_clk);
        read_data("simultaneous pop", rr);
        check("simultaneous pop const", rr, 32'h101);
      end
    join
    read_status("after simultaneous", r);
    check("after simultaneous const", r, 32'h43);
    for (int b = 2; b <= 5; b++) begin
      read_data($sformatf("order read %0d", b), r);
      check($sformatf("order read const %0d", b), r, 32'h100 + 32'(b));
    end

    // Reset during bit 3 of 0xFF with a byte pending and a nonzero rdt.
    send_byte(8'h11, 1'b1);
    bus_write(1'b0, 32'hFF);
    read_status("data write ignored", r);
    check("data write ignored const", r, 32'h11);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        @(posedge wb_clk);
        repeat (70) @(posedge wb_clk);
        #1;
        check("irq before reset", {31'd0, o_irq}, 32'd1);
        wb_rst = 1'b1;
        #1;
        check("midframe reset rdt", o_wb_rdt, 32'd0);
        check("midframe reset ack", {31'd0, o_wb_ack}, 32'd0);
        check("midframe reset irq", {31'd0, o_irq}, 32'd0);
        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 1'b0;
      end
    join
    sb_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    read_status("status after midframe reset", r);
    check("status after midframe reset const", r, 32'd0);
    send_byte(8'h55, 1'b1);
    read_data("after reset data", r);
    check("after reset data const", r, 32'h155);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
